ripple_cls8: RTL and testbench

RIPPLE_CLS8 -- requirements
Module: ripple_cls8

---
 rtl/ripple_pkg.sv | 15 +
 rtl/ripple_cls8_cla4.sv | 33 +++
 rtl/ripple_cls8.sv | 171 +++++++++++++++++
 tb/tb_ripple_cls8.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ripple_pkg.sv
// Shared definitions for the ripple_cls8 subtractor: datapath widths and
// the sequencing FSM state encoding.
package ripple_pkg;

  localparam int DATA_W  = 8;
  localparam int GROUP_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/ripple_cls8_cla4.sv
// cla4: 4-bit carry-lookahead adder built from per-bit generate/propagate
// terms. All carries are formed directly from c_in, so there is no ripple
// inside the group.
module cla4
  import ripple_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               c_in,
  output logic [GROUP_W-1:0] sum,
  output logic               c_out
);

  logic [GROUP_W-1:0] g;
  logic [GROUP_W-1:0] p;
  logic [GROUP_W:0]   c;

  // Expanded lookahead equations for every carry, then sum = p ^ carry-in
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = c_in;
    c[1] = g[0] | (p[0] & c_in);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c_in);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c_in);
    sum   = p ^ c[GROUP_W-1:0];
    c_out = c[GROUP_W];
  end

endmodule

// File: rtl/ripple_cls8.sv
// ripple_cls8: 8-bit subtractor computing A - B - b_in as A + ~B + ~b_in.
// A single cla4 group is reused: the low nibble is added in LO, the high
// nibble (with the registered inter-group carry) in HI, and the result is
// published in DONE. The requester holds en until it has consumed the result.
// Optional feature macro: RIPPLE_CLS8_OVF_EN adds the registered signed
// overflow output ovf.
module ripple_cls8
  import ripple_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              b_in,
  output logic [DATA_W-1:0] Output,
  output logic              b_out,
  output logic              ready
`ifdef RIPPLE_CLS8_OVF_EN
  ,
  output logic              ovf
`endif
);

  state_t state_q, state_d;

  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;
  logic               bin_q, bin_d;
  logic [GROUP_W-1:0] lo_sum_q, lo_sum_d;
  logic               carry_q, carry_d;
  logic [DATA_W-1:0]  out_q, out_d;
  logic               bout_q, bout_d;

  logic [GROUP_W-1:0] cla_a;
  logic [GROUP_W-1:0] cla_b;
  logic               cla_cin;
  logic [GROUP_W-1:0] cla_sum;
  logic               cla_cout;

`ifdef RIPPLE_CLS8_OVF_EN
  logic ovf_q, ovf_d;
  logic [DATA_W-1:0] diff_full;
`endif

  // State register; reset parks the sequencer in IDLE immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: dropping en aborts from any busy state back to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = en ? LO   : IDLE;
      LO:      state_d = en ? HI   : IDLE;
      HI:      state_d = en ? DONE : IDLE;
      DONE:    state_d = en ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: the result is valid exactly while parked in DONE
  always_comb begin
    ready = (state_q == DONE);
  end

  // Operand steering for the shared adder: high nibble with the saved carry
  // in HI, otherwise the low nibble with the inverted borrow as carry-in
  always_comb begin
    if (state_q == HI) begin
      cla_a   = a_q[DATA_W-1:GROUP_W];
      cla_b   = ~b_q[DATA_W-1:GROUP_W];
      cla_cin = carry_q;
    end else begin
      cla_a   = a_q[GROUP_W-1:0];
      cla_b   = ~b_q[GROUP_W-1:0];
      cla_cin = ~bin_q;
    end
  end

  cla4 u_cla4 (
    .a     (cla_a),
    .b     (cla_b),
    .c_in  (cla_cin),
    .sum   (cla_sum),
    .c_out (cla_cout)
  );

`ifdef RIPPLE_CLS8_OVF_EN
  // Full difference as it will appear on Output, used for the sign check
  always_comb begin
    diff_full = {cla_sum, lo_sum_q};
  end
`endif

  // Datapath next values: capture in IDLE, low half in LO, publish in HI;
  // everything else holds so an abort leaves the last result visible
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    bin_d    = bin_q;
    lo_sum_d = lo_sum_q;
    carry_d  = carry_q;
    out_d    = out_q;
    bout_d   = bout_q;
`ifdef RIPPLE_CLS8_OVF_EN
    ovf_d    = ovf_q;
`endif
    if (en) begin
      case (state_q)
        IDLE: begin
          a_d   = A;
          b_d   = B;
          bin_d = b_in;
        end
        LO: begin
          lo_sum_d = cla_sum;
          carry_d  = cla_cout;
        end
        HI: begin
          out_d  = {cla_sum, lo_sum_q};
          bout_d = ~cla_cout;
`ifdef RIPPLE_CLS8_OVF_EN
          ovf_d  = (a_q[DATA_W-1] != b_q[DATA_W-1]) &&
                   (diff_full[DATA_W-1] != a_q[DATA_W-1]);
`endif
        end
        default: ;
      endcase
    end
  end

  // Datapath registers; reset clears operands and the published result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      bin_q    <= 1'b0;
      lo_sum_q <= '0;
      carry_q  <= 1'b0;
      out_q    <= '0;
      bout_q   <= 1'b0;
`ifdef RIPPLE_CLS8_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      bin_q    <= bin_d;
      lo_sum_q <= lo_sum_d;
      carry_q  <= carry_d;
      out_q    <= out_d;
      bout_q   <= bout_d;
`ifdef RIPPLE_CLS8_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  // Drive the registered results onto the ports
  always_comb begin
    Output = out_q;
    b_out  = bout_q;
`ifdef RIPPLE_CLS8_OVF_EN
    ovf    = ovf_q;
`endif
  end

endmodule

// File: tb/tb_ripple_cls8.sv
// Testbench for ripple_cls8: table of directed vectors plus random vectors
// checked against an arithmetic reference, and hand-written sequences for
// abort, hold-in-DONE and asynchronous reset. Expected results go through a
// scoreboard queue. Build with RIPPLE_CLS8_OVF_EN defined to also check ovf.
module tb_ripple_cls8;

  logic       clk;
  logic       reset;
  logic       en;
  logic [7:0] A;
  logic [7:0] B;
  logic       b_in;
  logic [7:0] Output;
  logic       b_out;
  logic       ready;
`ifdef RIPPLE_CLS8_OVF_EN
  logic       ovf;
`endif

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] e_out;
    logic       e_bout;
    logic       e_ovf;
  } vec_t;

  typedef struct {
    logic [7:0] out;
    logic       bout;
    logic       ovf;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[9];

  int n_vec  = 0;
  int n_miss = 0;
  logic [7:0] last_out;
  logic       last_bout;

  ripple_cls8 dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .A      (A),
    .B      (B),
    .b_in   (b_in),
    .Output (Output),
    .b_out  (b_out),
    .ready  (ready)
`ifdef RIPPLE_CLS8_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counted, and reported on mismatch
  task automatic checkVal(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer subtraction, borrow from the 9th bit
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic bin);
    exp_t e;
    logic [8:0] d;
    d = {1'b0, a} - {1'b0, b} - {8'd0, bin};
    e.out  = d[7:0];
    e.bout = ({1'b0, a} < ({1'b0, b} + {8'd0, bin}));
    e.ovf  = (a[7] != b[7]) && (e.out[7] != a[7]);
    return e;
  endfunction

  // Drive a request at the falling edge and queue its expected result
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic bin,
                               input exp_t e);
    @(negedge clk);
    A    = a;
    B    = b;
    b_in = bin;
    en   = 1'b1;
    sb_q.push_back(e);
  endtask

  // Pop the oldest expected result and compare the DUT outputs
  task automatic checkOutput(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("[TB] FAIL %s_scoreboard: got empty queue, expected an entry", tag);
    end else begin
      e = sb_q.pop_front();
      checkVal({tag, "_out"}, Output, e.out);
      checkVal({tag, "_bout"}, {7'd0, b_out}, {7'd0, e.bout});
`ifdef RIPPLE_CLS8_OVF_EN
      checkVal({tag, "_ovf"}, {7'd0, ovf}, {7'd0, e.ovf});
`endif
      last_out  = e.out;
      last_bout = e.bout;
    end
  endtask

  // Walk the three edges of an operation, scrambling operands after capture
  task automatic waitResult(input string tag);
    @(posedge clk);
    #1;
    checkVal({tag, "_rdy_e1"}, {7'd0, ready}, 8'd0);
    A = 8'($urandom_range(0, 255));
    B = 8'($urandom_range(0, 255));
    b_in = ~b_in;
    @(posedge clk);
    #1;
    checkVal({tag, "_rdy_e2"}, {7'd0, ready}, 8'd0);
    @(posedge clk);
    #1;
    checkVal({tag, "_rdy_e3"}, {7'd0, ready}, 8'd1);
    checkOutput(tag);
  endtask

  // Drop en and confirm ready clears while the result is retained
  task automatic releaseEn(input string tag);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    #1;
    checkVal({tag, "_rel_rdy"}, {7'd0, ready}, 8'd0);
    checkVal({tag, "_rel_out"}, Output, last_out);
  endtask

  initial begin
    exp_t e;
    vecs[0] = '{8'd12,  8'd1,   1'b0, 8'd11,  1'b0, 1'b0};
    vecs[1] = '{8'd0,   8'd1,   1'b0, 8'd255, 1'b1, 1'b0};
    vecs[2] = '{8'h80,  8'h01,  1'b0, 8'h7F,  1'b0, 1'b1};
    vecs[3] = '{8'd5,   8'd5,   1'b1, 8'hFF,  1'b1, 1'b0};
    vecs[4] = '{8'hFF,  8'h00,  1'b0, 8'hFF,  1'b0, 1'b0};
    vecs[5] = '{8'h7F,  8'hFF,  1'b0, 8'h80,  1'b1, 1'b1};
    vecs[6] = '{8'h00,  8'h00,  1'b1, 8'hFF,  1'b1, 1'b0};
    vecs[7] = '{8'hA5,  8'h5A,  1'b0, 8'h4B,  1'b0, 1'b1};
    vecs[8] = '{8'h33,  8'h33,  1'b0, 8'h00,  1'b0, 1'b0};

    reset = 1'b1;
    en    = 1'b0;
    A     = 8'd0;
    B     = 8'd0;
    b_in  = 1'b0;
    last_out  = 8'd0;
    last_bout = 1'b0;
    #12;
    checkVal("reset_out", Output, 8'd0);
    checkVal("reset_bout", {7'd0, b_out}, 8'd0);
    checkVal("reset_ready", {7'd0, ready}, 8'd0);
`ifdef RIPPLE_CLS8_OVF_EN
    checkVal("reset_ovf", {7'd0, ovf}, 8'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] directed vectors");
    for (int i = 0; i < 9; i++) begin
      e.out  = vecs[i].e_out;
      e.bout = vecs[i].e_bout;
      e.ovf  = vecs[i].e_ovf;
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].bin, e);
      waitResult($sformatf("vec%0d", i));
      releaseEn($sformatf("vec%0d", i));
    end

    $display("[TB] random vectors");
    for (int i = 0; i < 12; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rc;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      applyStimulus(ra, rb, rc, model(ra, rb, rc));
      waitResult($sformatf("rnd%0d", i));
      releaseEn($sformatf("rnd%0d", i));
    end

    $display("[TB] abort during HI");
    applyStimulus(8'd12, 8'd1, 1'b0, model(8'd12, 8'd1, 1'b0));
    waitResult("abort_pre");
    releaseEn("abort_pre");
    applyStimulus(8'h40, 8'h10, 1'b0, model(8'h40, 8'h10, 1'b0));
    @(posedge clk);
    #1;
    checkVal("abort_rdy_e1", {7'd0, ready}, 8'd0);
    @(posedge clk);
    #1;
    checkVal("abort_rdy_e2", {7'd0, ready}, 8'd0);
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkVal("abort_rdy_idle", {7'd0, ready}, 8'd0);
      checkVal("abort_out_hold", Output, last_out);
      checkVal("abort_bout_hold", {7'd0, b_out}, {7'd0, last_bout});
    end
    @(negedge clk);
    A    = 8'h40;
    B    = 8'h10;
    b_in = 1'b0;
    en   = 1'b1;
    waitResult("abort_retry");

    $display("[TB] hold in DONE");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      A = 8'($urandom_range(0, 255));
      B = 8'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      checkVal("hold_rdy", {7'd0, ready}, 8'd1);
      checkVal("hold_out", Output, last_out);
      checkVal("hold_bout", {7'd0, b_out}, {7'd0, last_bout});
    end
    releaseEn("hold");

    $display("[TB] reset mid-LO");
    applyStimulus(8'h9C, 8'h21, 1'b0, model(8'h9C, 8'h21, 1'b0));
    void'(sb_q.pop_back());
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkVal("rst_mid_out", Output, 8'd0);
    checkVal("rst_mid_bout", {7'd0, b_out}, 8'd0);
    checkVal("rst_mid_ready", {7'd0, ready}, 8'd0);
`ifdef RIPPLE_CLS8_OVF_EN
    checkVal("rst_mid_ovf", {7'd0, ovf}, 8'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    A     = 8'h9C;
    B     = 8'h21;
    b_in  = 1'b1;
    sb_q.push_back(model(8'h9C, 8'h21, 1'b1));
    waitResult("rst_after");
    releaseEn("rst_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
